// File: rtl/alu_accum_seq.sv
// Sequential accumulator ALU: WIDTH-bit accumulator combined with a latched operand
// under an OFF/READY/RUN/ERROR state machine. MUL is an iterative shift-add over WIDTH cycles.
module alu_accum_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on_i,
  input  logic             load_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_READY = 2'b01,
    S_RUN   = 2'b10,
    S_ERROR = 2'b11
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      cnt_q;
  logic               done_q;
  logic               ovf_q;

  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [WIDTH-1:0]   result;
  logic               res_ovf;
  logic               finish;

  // opnd_q doubles as the multiplier shift register; acc_q is the multiplicand and holds during RUN.
  always_comb begin
    partial = '0;
    if (opnd_q[0]) partial = {{WIDTH{1'b0}}, acc_q} << cnt_q;
    prod_d  = prod_q + partial;
    add_w   = {1'b0, acc_q} + {1'b0, opnd_q};
    sub_w   = {1'b0, acc_q} - {1'b0, opnd_q};
    result  = '0;
    res_ovf = 1'b0;
    finish  = 1'b1;
    case (op_q)
      OP_AND: result = acc_q & opnd_q;
      OP_OR:  result = acc_q | opnd_q;
      OP_XOR: result = acc_q ^ opnd_q;
      OP_NOT: result = ~acc_q;
      OP_ADD: begin
        result  = add_w[WIDTH-1:0];
        res_ovf = add_w[WIDTH];
      end
      OP_SUB: begin
        result  = sub_w[WIDTH-1:0];
        res_ovf = sub_w[WIDTH];
      end
      OP_MUL: begin
        result  = prod_d[WIDTH-1:0];
        res_ovf = |prod_d[2*WIDTH-1:WIDTH];
        finish  = (cnt_q == LAST);
      end
      OP_CLR: result = '0;
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      acc_q   <= '0;
      op_q    <= OP_AND;
      opnd_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!on_i) begin
        state_q <= S_OFF;
      end else begin
        case (state_q)
          S_OFF: state_q <= S_READY;
          S_READY: begin
            if (load_i) begin
              acc_q <= a_i;
              ovf_q <= 1'b0;
            end else if (start_i) begin
              op_q    <= op_i;
              opnd_q  <= b_i;
              prod_q  <= '0;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
              state_q <= S_RUN;
            end
          end
          S_RUN: begin
            if (finish) begin
              acc_q  <= result;
              done_q <= 1'b1;
              if (res_ovf) begin
                ovf_q   <= 1'b1;
                state_q <= S_ERROR;
              end else begin
                state_q <= S_READY;
              end
            end else begin
              prod_q <= prod_d;
              opnd_q <= opnd_q >> 1;
              cnt_q  <= cnt_q + CW'(1);
            end
          end
          S_ERROR: state_q <= S_READY;
          default: state_q <= S_OFF;
        endcase
      end
    end
  end

  assign acc_o   = acc_q;
  assign busy_o  = (state_q == S_RUN);
  assign done_o  = done_q;
  assign ovf_o   = ovf_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq (WIDTH=8): directed operations push expected {state, ovf, acc}
// into a queue; a monitor pops and compares on every done pulse.
module tb_alu_accum_seq;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         on_i;
  logic         load_i;
  logic         start_i;
  logic [2:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [W-1:0] acc_o;
  logic         busy_o;
  logic         done_o;
  logic         ovf_o;
  logic [1:0]   state_o;

  int checks;
  int failures;
  int cyc;
  logic [W+2:0] exp_q[$];

  alu_accum_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .on_i(on_i), .load_i(load_i), .start_i(start_i),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .acc_o(acc_o), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o), .state_o(state_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done with acc=0x%0h expected no done", acc_o);
      end else begin
        logic [W+2:0] e;
        e = exp_q.pop_front();
        if ({state_o, ovf_o, acc_o} !== e) begin
          failures++;
          $display("FAIL result: got state=%0d ovf=%0d acc=0x%0h expected state=%0d ovf=%0d acc=0x%0h",
                   state_o, ovf_o, acc_o, e[W+2:W+1], e[W], e[W-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic do_load(input logic [W-1:0] v);
    @(posedge clk); #1;
    load_i = 1'b1; a_i = v;
    @(posedge clk); #1;
    load_i = 1'b0;
    check("load_acc", acc_o, v);
    check("load_ovf", ovf_o, 0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] b, input logic [W-1:0] exp_acc,
                       input logic exp_ovf, input int exp_lat, input bit inject);
    int n;
    bit got;
    exp_q.push_back({(exp_ovf ? 2'b11 : 2'b01), exp_ovf, exp_acc});
    @(posedge clk); #1;
    start_i = 1'b1; op_i = op; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = 3'b111; b_i = 8'h5A;
    n = cyc;
    check("busy_run", {busy_o, state_o}, {1'b1, 2'b10});
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (done_o) got = 1'b1;
      if (inject && k == 2) begin
        load_i = 1'b1; start_i = 1'b1; a_i = 8'hAA;
      end
      if (inject && k == 3) begin
        load_i = 1'b0; start_i = 1'b0;
      end
    end
    check("done_seen", got, 1);
    check("latency", cyc - n, exp_lat);
    if (exp_ovf) begin
      @(negedge clk);
      check("error_one_cycle", state_o, 2'b01);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; on_i = 1'b0; load_i = 1'b0; start_i = 1'b0;
    op_i = 3'b000; a_i = '0; b_i = '0;
    #1;
    check("rst_acc", acc_o, 0);
    check("rst_state", state_o, 0);
    check("rst_flags", {busy_o, done_o, ovf_o}, 0);
    #11;
    on_i = 1'b1; rst = 1'b0;
    @(negedge clk);
    check("power_up", state_o, 2'b01);

    // logic chain
    do_load(8'hF0);
    do_op(3'b000, 8'h3C, 8'h30, 1'b0, 1, 1'b0);
    do_op(3'b001, 8'h0F, 8'h3F, 1'b0, 1, 1'b0);
    do_op(3'b010, 8'hFF, 8'hC0, 1'b0, 1, 1'b0);
    do_op(3'b011, 8'h00, 8'h3F, 1'b0, 1, 1'b0);

    // add/sub wrap
    do_load(8'hFF);
    do_op(3'b100, 8'h02, 8'h01, 1'b1, 1, 1'b0);
    do_op(3'b101, 8'h05, 8'hFC, 1'b1, 1, 1'b0);
    check("ovf_sticky", ovf_o, 1);
    do_load(8'h10);
    do_op(3'b100, 8'h22, 8'h32, 1'b0, 1, 1'b0);
    do_op(3'b101, 8'h32, 8'h00, 1'b0, 1, 1'b0);
    do_load(8'h9D);
    do_op(3'b111, 8'h44, 8'h00, 1'b0, 1, 1'b0);

    // multiply, first one with load/start pulsed mid-run
    do_load(8'h0C);
    do_op(3'b110, 8'h0B, 8'h84, 1'b0, 8, 1'b1);
    do_load(8'h20);
    do_op(3'b110, 8'h10, 8'h00, 1'b1, 8, 1'b0);
    do_load(8'hFF);
    do_op(3'b110, 8'h01, 8'hFF, 1'b0, 8, 1'b0);

    // load has priority over start
    @(posedge clk); #1;
    load_i = 1'b1; start_i = 1'b1; a_i = 8'h77; op_i = 3'b111;
    @(posedge clk); #1;
    load_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("prio_acc", acc_o, 8'h77);
    check("prio_state", {busy_o, state_o}, {1'b0, 2'b01});

    // power drop at MUL cycle 4
    do_load(8'h55);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'b110; b_i = 8'h03;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 on_i = 1'b0;
    @(posedge clk); #1;
    check("drop_state", {busy_o, state_o}, {1'b0, 2'b00});
    check("drop_acc", acc_o, 8'h55);
    check("drop_ovf", ovf_o, 0);
    repeat (12) @(posedge clk);
    #1 on_i = 1'b1;
    @(posedge clk); #1;
    check("repower", state_o, 2'b01);
    check("repower_acc", acc_o, 8'h55);

    // asynchronous reset mid-MUL
    do_load(8'h33);
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'b110; b_i = 8'h07;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_acc", acc_o, 0);
    check("arst_state", {busy_o, state_o}, 0);
    #4 rst = 1'b0;
    @(negedge clk);
    check("arst_ready", state_o, 2'b01);
    repeat (12) @(posedge clk);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
